// File: rtl/axi4_lite_master_pkg.sv
// Shared AXI4-Lite definitions for the command-driven master and for the
// sequencers / bridges that feed it.
//   - RESP_* : encodings of BRESP/RRESP
//   - axi_lite_cmd_t : one request (write flag, byte address, data, strobes)
//   - axi_lite_rsp_t : one response (write flag, read data, response code)
package axi4_lite_master_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic                  write;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
  } axi_lite_cmd_t;

  typedef struct packed {
    logic                  write;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            resp;
  } axi_lite_rsp_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Command-driven AXI4-Lite master. Accepts one command on the cmd_* stream,
// runs the matching AXI4-Lite write (AW+W then B) or read (AR then R)
// transaction, and returns the result on the rsp_* stream. Only one
// transaction is ever in flight; a new command is taken only in IDLE.
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   cmd_*                 command stream in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                 response stream out (valid/ready, write, rdata, resp)
//   aw*, w*, b*, ar*, r*  AXI4-Lite master channels
// Every output is either a register or a decode of state plus registers,
// so no output depends combinationally on an input.
module axi4_lite_master
  import axi4_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } mst_state_e;

  mst_state_e state_q, state_d;

  // Command holding register, write-phase tracking and captured response.
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;
  logic [15:0]           wr_count_q;
  logic [15:0]           rd_count_q;

  logic aw_hs_s;
  logic w_hs_s;

  // AW and W are independent: each valid stays up until its own handshake.
  assign aw_hs_s = (state_q == WR_REQ) && !aw_done_q && awready;
  assign w_hs_s  = (state_q == WR_REQ) && !w_done_q && wready;

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = cmd_write ? WR_REQ : RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        // Leave once both halves are done, counting a handshake happening now.
        if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
          state_d = WR_RESP;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d = RSP;
        end else begin
          state_d = WR_RESP;
        end
      end
      RD_REQ: begin
        if (arready) begin
          state_d = RD_RESP;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_RESP: begin
        if (rvalid) begin
          state_d = RSP;
        end else begin
          state_d = RD_RESP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/valid outputs decoded from state and the phase-done flags.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    awvalid   = (state_q == WR_REQ) && !aw_done_q;
    wvalid    = (state_q == WR_REQ) && !w_done_q;
    bready    = (state_q == WR_RESP);
    arvalid   = (state_q == RD_REQ);
    rready    = (state_q == RD_RESP);
    rsp_valid = (state_q == RSP);
  end

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  // Command latch, phase tracking, response capture and debug counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      wr_count_q  <= 16'd0;
      rd_count_q  <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            write_q   <= cmd_write;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        WR_REQ: begin
          if (aw_hs_s) begin
            aw_done_q <= 1'b1;
          end
          if (w_hs_s) begin
            w_done_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= bresp;
          end
        end
        RD_RESP: begin
          if (rvalid) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= rdata;
            rsp_resp_q  <= rresp;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            if (rsp_write_q) begin
              wr_count_q <= wr_count_q + 16'd1;
            end else begin
              rd_count_q <= rd_count_q + 16'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Command-driven AXI4-Lite master that converts a simple request/response stream into AXI4-Lite transactions.
- Sits directly upstream of axi4_lite_slave: its AXI ports connect to the slave's AW/W/B/AR/R channels. Its command side is driven by a testbench sequencer or a CPU-side bridge.
- At most one transaction is outstanding at any time.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width (multiple of 8).
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width (derived; do not override).

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  STRB_WIDTH  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP
- awvalid, awready, awaddr, awprot(3)  out/in/out/out  AW channel
- wvalid, wready, wdata, wstrb  out/in/out/out  W channel
- bvalid, bready, bresp  in/out/in  B channel
- arvalid, arready, araddr, arprot(3)  out/in/out/out  AR channel
- rvalid, rready, rdata, rresp  in/out/in/in  R channel

Behaviour:
- Reset (areset=1 at a rising edge of aclk):
  - State goes to IDLE.
  - All valid/ready outputs are 0, except that cmd_ready is 1 in IDLE.
  - All data, address and response outputs are 0. awprot and arprot are fixed at 3'b000.
- cmd_ready = (state == IDLE). This is combinational from state only and never depends on cmd_valid.
- IDLE: when cmd_valid and cmd_ready are both 1, latch addr, wdata, wstrb and write.
  - Write: go to WR_REQ; awvalid and wvalid become 1 on the next cycle.
  - Read: go to RD_REQ; arvalid becomes 1 on the next cycle.
  - Latency from cmd handshake to valid on the bus is 1 cycle.
- WR_REQ: awvalid and wvalid are driven independently.
  - awvalid drops the cycle after the AW handshake; wvalid drops the cycle after the W handshake.
  - Both handshakes in the same cycle is legal; the two may occur in either order.
  - When both are done (tracked by aw_done_q and w_done_q, or by the current-cycle handshake), go to WR_RESP with bready = 1.
  - awaddr/wdata/wstrb hold stable while the matching valid is 1.
- WR_RESP: bready = 1. On B handshake, capture bresp, set rsp_write = 1 and rsp_rdata = 0, then go to RSP.
- RD_REQ: arvalid holds until the AR handshake, then go to RD_RESP with rready = 1.
- RD_RESP: rready = 1. On R handshake, capture rdata and rresp, set rsp_write = 0, then go to RSP.
- RSP: rsp_valid = 1, and rsp_* stay stable until rsp_ready = 1. On the rsp handshake, go to IDLE (cmd_ready = 1 on the next cycle).
- Valid stability: no valid (awvalid, wvalid, arvalid, rsp_valid) deasserts before its handshake.
- No output depends combinationally on any input ready/valid. All outputs are registered or decoded from state.
- The block never issues a new command before the response is consumed, so at most one transaction is outstanding.
- The same-cycle response path is legal:
  - bvalid may already be 1 when WR_RESP is entered; it is accepted in the first WR_RESP cycle.
  - rvalid likewise in RD_RESP.
- Reset mid-transaction aborts immediately: all valids drop next cycle and the in-flight response is discarded. The connected slave is expected to be reset at the same time.
- SLVERR/DECERR are passed through unchanged in rsp_resp; the block does no retry.
- Handshake counters wr_count_q and rd_count_q are 16 bits each:
  - They increment on rsp handshake and wrap from 0xFFFF to 0.
  - They are internal debug only, visible to the bench hierarchically.

Decomposition:
- axi_pkg: reuse RESP_OKAY / RESP_SLVERR.
- axi_pkg: add typedef axi_lite_cmd_t (write, addr, wdata, wstrb) and axi_lite_rsp_t (write, rdata, resp) as packed structs for sequencers and bridges.
- FSM enum mst_state_e {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} is local to the module.
- No sub-module; the block is a single FSM with a command holding register.

Test Plan:
- Write 0xCAFE_F00D to 0x18 (SCRATCH), wstrb 0xF, then read 0x18 -> two responses: {write=1, resp=OKAY}, then {write=0, rdata=0xCAFE_F00D, resp=OKAY}.
- Read 0x1C (VERSION) -> rsp_rdata == IP_VERSION, resp OKAY; arvalid high exactly 1 cycle with arready tied 1.
- Bench stub holds wready=0 for 5 cycles with awready=1, then 5 cycles with the order swapped -> awvalid drops after its handshake, wvalid persists, exactly one B accepted per command, and responses are OKAY.
- Write to 0x40 (out of range) -> rsp_resp == SLVERR; read 0x40 -> rsp_rdata 0xDEAD_BEEF, resp SLVERR.
- rsp_ready held 0 for 10 cycles -> rsp_valid and data stable, cmd_ready stays 0, a new cmd_valid is not accepted until the rsp handshake.
- areset asserted while in WR_REQ with awready=0 -> next cycle all valids are 0, cmd_ready=1, no rsp_valid; a subsequent write completes normally.
